// File: rtl/led_matrix_if.sv
// Game-state to frame bus between the game-logic block (master) and led_matrix (slave).
// Carries the ball, paddle and score inputs plus the registered 64x64 frame.
interface led_matrix_if;
  logic [5:0]    bx;
  logic [5:0]    by;
  logic [5:0]    p1y;
  logic [5:0]    p2y;
  logic [2:0]    sc1;
  logic [2:0]    sc2;
  logic [4095:0] matrix;

  modport master (
    output bx, by, p1y, p2y, sc1, sc2,
    input  matrix
  );

  modport slave (
    input  bx, by, p1y, p2y, sc1, sc2,
    output matrix
  );
endinterface

// File: rtl/led_matrix.sv
// Renders ball, paddles and scores into a registered 64x64 frame (row-major, 1-cycle latency).
// Optional macro LEDMATRIX_NET_EN adds a dashed centre net at column 32.
module led_matrix #(
  parameter int PADDLE_LEN = 8,
  parameter int P1_COL     = 2,
  parameter int P2_COL     = 61
) (
  input  logic         clk,
  input  logic         rst_n,
  led_matrix_if.slave  bus
);

  // Span ends are kept in 7 bits so anything past row/column 63 is clipped, never wrapped.
  logic [6:0]    w_bx_lo, w_bx_hi;
  logic [6:0]    w_by_lo, w_by_hi;
  logic [6:0]    w_p1_lo, w_p1_hi;
  logic [6:0]    w_p2_lo, w_p2_hi;
  logic [6:0]    w_sc1_hi;
  logic [6:0]    w_sc2_lo;
  logic [4095:0] w_frame;
  logic [4095:0] r_matrix;

  assign w_bx_lo  = {1'b0, bus.bx};
  assign w_bx_hi  = {1'b0, bus.bx} + 7'd1;
  assign w_by_lo  = {1'b0, bus.by};
  assign w_by_hi  = {1'b0, bus.by} + 7'd1;
  assign w_p1_lo  = {1'b0, bus.p1y};
  assign w_p1_hi  = {1'b0, bus.p1y} + 7'(PADDLE_LEN - 1);
  assign w_p2_lo  = {1'b0, bus.p2y};
  assign w_p2_hi  = {1'b0, bus.p2y} + 7'(PADDLE_LEN - 1);
  assign w_sc1_hi = {4'd0, bus.sc1};
  assign w_sc2_lo = 7'd63 - {4'd0, bus.sc2};

  // Each pixel is the OR of every layer that covers it; row/column are elaboration constants.
  for (genvar gr = 0; gr < 64; gr++) begin : g_row
    for (genvar gc = 0; gc < 64; gc++) begin : g_col
      localparam logic [6:0] R7     = 7'(gr);
      localparam logic [6:0] C7     = 7'(gc);
      localparam logic       IS_P1  = (gc == P1_COL);
      localparam logic       IS_P2  = (gc == P2_COL);
      localparam logic       IS_S1  = (gr == 0) && (gc >= 1);
      localparam logic       IS_S2  = (gr == 0) && (gc <= 62);
`ifdef LEDMATRIX_NET_EN
      localparam logic       IS_NET = (gc == 32) && ((gr % 4) < 2);
`else
      localparam logic       IS_NET = 1'b0;
`endif

      logic w_ball, w_pad1, w_pad2, w_score1, w_score2;

      assign w_ball   = (C7 >= w_bx_lo) && (C7 <= w_bx_hi) &&
                        (R7 >= w_by_lo) && (R7 <= w_by_hi);
      assign w_pad1   = IS_P1 && (R7 >= w_p1_lo) && (R7 <= w_p1_hi);
      assign w_pad2   = IS_P2 && (R7 >= w_p2_lo) && (R7 <= w_p2_hi);
      assign w_score1 = IS_S1 && (C7 <= w_sc1_hi);
      assign w_score2 = IS_S2 && (C7 >= w_sc2_lo);

      assign w_frame[64*gr + gc] = w_ball | w_pad1 | w_pad2 | w_score1 | w_score2 | IS_NET;
    end
  end

  // Output register: whole frame captured every edge, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) r_matrix <= '0;
    else        r_matrix <= w_frame;
  end

  assign bus.matrix = r_matrix;

endmodule

// File: tb/tb_led_matrix.sv
// Self-checking bench for led_matrix: painted-layer reference model compared every cycle,
// plus hand-built literal frames for reset, nominal, clipping, max-score, overlap and net cases.
module tb_led_matrix;
  localparam int PL = 8;
  localparam int C1 = 2;
  localparam int C2 = 61;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_matrix_if bus();

  led_matrix #(.PADDLE_LEN(PL), .P1_COL(C1), .P2_COL(C2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [4095:0] exp_q    = '0;
  logic          exp_ok   = 1'b0;
  logic          cmp_en   = 1'b1;
  logic [4095:0] lit;

  // Reference: paint each layer onto a blank canvas, dropping anything off the panel.
  function automatic logic [4095:0] model(int bx, int by, int p1, int p2, int s1, int s2);
    logic [4095:0] f = '0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++)
        if (bx + dx < 64 && by + dy < 64) f[64*(by+dy) + bx + dx] = 1'b1;
    for (int k = 0; k < PL; k++) begin
      if (p1 + k < 64) f[64*(p1+k) + C1] = 1'b1;
      if (p2 + k < 64) f[64*(p2+k) + C2] = 1'b1;
    end
    for (int k = 1; k <= s1; k++) f[k] = 1'b1;
    for (int k = 0; k < s2; k++)  f[62-k] = 1'b1;
`ifdef LEDMATRIX_NET_EN
    for (int r = 0; r < 64; r++)
      if ((r % 4) < 2) f[64*r + 32] = 1'b1;
`endif
    return f;
  endfunction

  task automatic check(input string name, input logic [4095:0] got, input logic [4095:0] exp);
    int idx;
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      idx = 0;
      for (int i = 0; i < 4096; i++)
        if (got[i] !== exp[i]) begin idx = i; break; end
      $display("FAIL %s at t=%0t: first differing pixel row=%0d col=%0d got=%b expected=%b",
               name, $time, idx / 64, idx % 64, got[idx], exp[idx]);
    end
  endtask

  task automatic drive(input int a, input int b, input int c, input int d, input int e, input int f);
    @(negedge clk); #1;
    bus.bx  = 6'(a);
    bus.by  = 6'(b);
    bus.p1y = 6'(c);
    bus.p2y = 6'(d);
    bus.sc1 = 3'(e);
    bus.sc2 = 3'(f);
  endtask

  function automatic int rnd6();
    if ($urandom_range(0, 3) == 0) return 56 + int'($urandom_range(0, 7));
    return int'($urandom_range(0, 63));
  endfunction

  task automatic lit_net();
`ifdef LEDMATRIX_NET_EN
    for (int r = 0; r < 64; r++)
      if ((r % 4) < 2) lit[64*r + 32] = 1'b1;
`endif
  endtask

  // Expected frame follows the inputs sampled at each rising edge.
  always @(posedge clk) begin
    if (!rst_n) exp_q = '0;
    else        exp_q = model(int'(bus.bx), int'(bus.by), int'(bus.p1y), int'(bus.p2y),
                              int'(bus.sc1), int'(bus.sc2));
    exp_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (exp_ok && cmp_en) check("frame_vs_model", bus.matrix, exp_q);
  end

  initial begin
    bus.bx  = 6'($urandom);
    bus.by  = 6'($urandom);
    bus.p1y = 6'($urandom);
    bus.p2y = 6'($urandom);
    bus.sc1 = 3'($urandom);
    bus.sc2 = 3'($urandom);
    rst_n   = 1'b0;
    @(posedge clk); #2;
    check("reset_all_zero", bus.matrix, '0);

    drive(31, 31, 20, 20, 2, 1);
    rst_n = 1'b1;
    @(posedge clk); #2;
    lit = '0;
    lit[1] = 1'b1; lit[2] = 1'b1; lit[62] = 1'b1;
    for (int r = 20; r <= 27; r++) begin lit[64*r+2] = 1'b1; lit[64*r+61] = 1'b1; end
    for (int r = 31; r <= 32; r++) begin lit[64*r+31] = 1'b1; lit[64*r+32] = 1'b1; end
    lit_net();
    check("nominal", bus.matrix, lit);

    drive(63, 63, 60, 58, 0, 0);
    @(posedge clk); #2;
    lit = '0;
    lit[64*63+63] = 1'b1;
    for (int r = 60; r <= 63; r++) lit[64*r+2]  = 1'b1;
    for (int r = 58; r <= 63; r++) lit[64*r+61] = 1'b1;
    lit_net();
    check("clipping", bus.matrix, lit);

    drive(31, 31, 40, 40, 7, 7);
    @(posedge clk); #2;
    lit = '0;
    for (int c = 1; c <= 7; c++)   lit[c] = 1'b1;
    for (int c = 56; c <= 62; c++) lit[c] = 1'b1;
    for (int r = 40; r <= 47; r++) begin lit[64*r+2] = 1'b1; lit[64*r+61] = 1'b1; end
    for (int r = 31; r <= 32; r++) begin lit[64*r+31] = 1'b1; lit[64*r+32] = 1'b1; end
    lit_net();
    check("max_scores", bus.matrix, lit);

    drive(1, 20, 20, 50, 0, 0);
    @(posedge clk); #2;
    lit = '0;
    for (int r = 20; r <= 21; r++) begin lit[64*r+1] = 1'b1; lit[64*r+2] = 1'b1; end
    for (int r = 20; r <= 27; r++) lit[64*r+2]  = 1'b1;
    for (int r = 50; r <= 57; r++) lit[64*r+61] = 1'b1;
    lit_net();
    check("overlap", bus.matrix, lit);

    drive(10, 10, 10, 10, 0, 0);
    @(posedge clk); #2;
    lit = '0;
    for (int r = 10; r <= 11; r++) begin lit[64*r+10] = 1'b1; lit[64*r+11] = 1'b1; end
    for (int r = 10; r <= 17; r++) begin lit[64*r+2] = 1'b1; lit[64*r+61] = 1'b1; end
    lit_net();
    check("column32_net", bus.matrix, lit);

    // Mid-operation reset with live inputs.
    drive(5, 5, 5, 5, 3, 3);
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("midop_reset", bus.matrix, '0);
    rst_n = 1'b1;

    for (int n = 0; n < 2000; n++) begin
      drive(rnd6(), rnd6(), rnd6(), rnd6(), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      rst_n = ($urandom_range(0, 40) != 0);
    end

    @(negedge clk); #1;
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
